bp_me_cache_dma_to_ram: RTL and testbench

Memory-side endpoint for the L2 cache slice's DMA channel. Consumes the block-granular command header plus dword data beats the cache slice emits. Executes each block as a sequence of single-dword accesses on a simple synchronous RAM port. Returns a response header and, for reads, dword data beats back to the cache slice. Used in tiles and testbenches that back the L2 with on-chip SRAM instead of an off-chip DRAM controller.

---
 rtl/bp_me_pkg.sv | 51 +++++
 rtl/bp_me_cache_dma_to_ram.sv | 177 +++++++++++++++++
 tb/tb_bp_me_cache_dma_to_ram.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_me_pkg.sv
// Shared types for the DMA-to-RAM memory endpoint: configuration table, bedrock mem header
// layout and the endpoint FSM state encoding.
package bp_me_pkg;

   typedef enum logic [0:0] {
      e_bp_default_cfg = 1'b0
   } bp_params_e;

   localparam int paddr_width_gp   = 40;
   localparam int payload_width_gp = 16;

   typedef enum logic [3:0] {
      e_bedrock_mem_rd    = 4'd0,
      e_bedrock_mem_wr    = 4'd1,
      e_bedrock_mem_uc_rd = 4'd2,
      e_bedrock_mem_uc_wr = 4'd3,
      e_bedrock_mem_pre   = 4'd4,
      e_bedrock_mem_amo   = 4'd5
   } bp_bedrock_mem_type_e;

   typedef struct packed {
      logic [payload_width_gp-1:0] payload;
      logic [2:0]                  size;
      logic [paddr_width_gp-1:0]   addr;
      bp_bedrock_mem_type_e        msg_type;
   } bp_bedrock_mem_header_s;

   localparam int cce_mem_msg_header_width_gp = $bits(bp_bedrock_mem_header_s);

   typedef enum logic [1:0] {
      e_idle  = 2'd0,
      e_write = 2'd1,
      e_read  = 2'd2,
      e_resp  = 2'd3
   } bp_me_dma_ram_state_e;

   function automatic int unsigned dword_width_f(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: dword_width_f = 64;
         default:          dword_width_f = 64;
      endcase
   endfunction

   function automatic int unsigned block_width_f(input bp_params_e cfg);
      case (cfg)
         e_bp_default_cfg: block_width_f = 512;
         default:          block_width_f = 512;
      endcase
   endfunction

endpackage

// File: rtl/bp_me_cache_dma_to_ram.sv
// L2 DMA channel endpoint backed by a single-dword synchronous RAM port.
// Define BP_ME_DMA_RAM_BOUNDS_EN to suppress out-of-range accesses and raise a sticky error_o.
module bp_me_cache_dma_to_ram
   import bp_me_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_default_cfg,
   parameter int ram_els_p = 2**16,
   localparam int dword_width_lp = dword_width_f(bp_params_p),
   localparam int block_width_lp = block_width_f(bp_params_p),
   localparam int beats_lp = block_width_lp / dword_width_lp,
   localparam int cnt_width_lp = $clog2(beats_lp),
   localparam int ram_addr_width_lp = (ram_els_p > 1) ? $clog2(ram_els_p) : 1,
   localparam int cce_mem_msg_header_width_lp = cce_mem_msg_header_width_gp
)(
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [cce_mem_msg_header_width_lp-1:0] mem_cmd_header_i,
   input  logic                                   mem_cmd_header_v_i,
   output logic                                   mem_cmd_header_yumi_o,
   input  logic [dword_width_lp-1:0]              mem_cmd_data_i,
   input  logic                                   mem_cmd_data_v_i,
   output logic                                   mem_cmd_data_yumi_o,
   output logic [cce_mem_msg_header_width_lp-1:0] mem_resp_header_o,
   output logic                                   mem_resp_header_v_o,
   input  logic                                   mem_resp_header_ready_i,
   output logic [dword_width_lp-1:0]              mem_resp_data_o,
   output logic                                   mem_resp_data_v_o,
   input  logic                                   mem_resp_data_ready_i,
   output logic                                   ram_v_o,
   output logic                                   ram_w_o,
   output logic [ram_addr_width_lp-1:0]           ram_addr_o,
   output logic [dword_width_lp-1:0]              ram_data_o,
   input  logic                                   ram_ready_i,
   input  logic [dword_width_lp-1:0]              ram_data_i,
   output logic                                   error_o
);

   localparam int byte_off_lp  = $clog2(dword_width_lp / 8);
   localparam int blk_width_lp = ram_addr_width_lp - cnt_width_lp;

   bp_me_dma_ram_state_e    r_state, w_state_next;
   bp_bedrock_mem_header_s  w_cmd_hdr, r_hdr;
   logic [blk_width_lp-1:0] r_base_blk;
   logic [cnt_width_lp-1:0] r_cnt, r_out_cnt;
   logic                    r_issue_done, r_hdr_sent, r_rd_pending, r_oob;
   logic [1:0]              r_fifo_cnt;
   logic                    r_wptr, r_rptr;
   logic [dword_width_lp-1:0] r_fifo_mem [2];
   logic w_oob, w_issue, w_issue_acc, w_resp_hdr_hs, w_resp_data_hs;
   logic w_last_cnt, w_last_out, w_fifo_push, w_fifo_pop;

   assign w_cmd_hdr = mem_cmd_header_i;

`ifdef BP_ME_DMA_RAM_BOUNDS_EN
   logic r_error;
   assign w_oob = |w_cmd_hdr.addr[paddr_width_gp-1:byte_off_lp+ram_addr_width_lp];

   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_error <= 1'b0;
      else if (mem_cmd_header_yumi_o && w_oob)
         r_error <= 1'b1;
   end
   assign error_o = r_error;
`else
   assign w_oob   = 1'b0;
   assign error_o = 1'b0;
`endif

   assign w_resp_hdr_hs  = mem_resp_header_v_o & mem_resp_header_ready_i;
   assign w_resp_data_hs = mem_resp_data_v_o & mem_resp_data_ready_i;
   assign w_last_cnt     = (r_cnt == cnt_width_lp'(beats_lp - 1));
   assign w_last_out     = (r_out_cnt == cnt_width_lp'(beats_lp - 1));
   assign w_fifo_push    = r_rd_pending;
   assign w_fifo_pop     = w_resp_data_hs;

   // Block base is fixed; only the in-block counter varies, so no carry leaves the block.
   assign ram_addr_o        = {r_base_blk, r_cnt};
   assign ram_data_o        = mem_cmd_data_i;
   assign mem_resp_header_o = r_hdr;
   assign mem_resp_data_o   = r_fifo_mem[r_rptr];

   always_ff @(posedge clk_i) begin
      if (reset_i)
         r_state <= e_idle;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         e_idle:  if (mem_cmd_header_v_i)
                     w_state_next = (w_cmd_hdr.msg_type == e_bedrock_mem_wr) ? e_write : e_read;
         e_write: if (mem_cmd_data_yumi_o && w_last_cnt) w_state_next = e_resp;
         e_read:  if (w_resp_data_hs && w_last_out) w_state_next = e_idle;
         e_resp:  if (w_resp_hdr_hs) w_state_next = e_idle;
         default: w_state_next = e_idle;
      endcase
   end

   always_comb begin
      mem_cmd_header_yumi_o = 1'b0;
      mem_cmd_data_yumi_o   = 1'b0;
      mem_resp_header_v_o   = 1'b0;
      mem_resp_data_v_o     = 1'b0;
      ram_v_o               = 1'b0;
      ram_w_o               = 1'b0;
      w_issue               = 1'b0;
      w_issue_acc           = 1'b0;
      case (r_state)
         e_idle: mem_cmd_header_yumi_o = mem_cmd_header_v_i;
         e_write: begin
            ram_w_o             = 1'b1;
            ram_v_o             = mem_cmd_data_v_i & ~r_oob;
            mem_cmd_data_yumi_o = mem_cmd_data_v_i & (ram_ready_i | r_oob);
         end
         e_read: begin
            // Held beats plus the read in flight never exceed the two buffer slots.
            w_issue = ~r_issue_done & (({1'b0, r_fifo_cnt} + {2'b00, r_rd_pending}) < 3'd2);
            ram_v_o             = w_issue & ~r_oob;
            w_issue_acc         = w_issue & (ram_ready_i | r_oob);
            mem_resp_header_v_o = ~r_hdr_sent;
            mem_resp_data_v_o   = r_hdr_sent & (r_fifo_cnt != 2'd0);
         end
         e_resp: mem_resp_header_v_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_hdr        <= '0;
         r_base_blk   <= '0;
         r_oob        <= 1'b0;
         r_cnt        <= '0;
         r_out_cnt    <= '0;
         r_issue_done <= 1'b0;
         r_hdr_sent   <= 1'b0;
         r_rd_pending <= 1'b0;
         r_fifo_cnt   <= 2'd0;
         r_wptr       <= 1'b0;
         r_rptr       <= 1'b0;
      end else begin
         if (mem_cmd_header_yumi_o) begin
            r_hdr        <= w_cmd_hdr;
            r_base_blk   <= w_cmd_hdr.addr[byte_off_lp+cnt_width_lp +: blk_width_lp];
            r_oob        <= w_oob;
            r_cnt        <= '0;
            r_out_cnt    <= '0;
            r_issue_done <= 1'b0;
            r_hdr_sent   <= 1'b0;
         end
         if (mem_cmd_data_yumi_o || w_issue_acc)
            r_cnt <= r_cnt + cnt_width_lp'(1);
         if (w_issue_acc && w_last_cnt)
            r_issue_done <= 1'b1;
         if (w_resp_hdr_hs && (r_state == e_read))
            r_hdr_sent <= 1'b1;
         if (w_fifo_pop) begin
            r_out_cnt <= r_out_cnt + cnt_width_lp'(1);
            r_rptr    <= ~r_rptr;
         end
         if (w_fifo_push)
            r_wptr <= ~r_wptr;
         r_rd_pending <= w_issue_acc;
         r_fifo_cnt   <= r_fifo_cnt + {1'b0, w_fifo_push} - {1'b0, w_fifo_pop};
      end
   end

   // Suppressed out-of-range reads still flow through the buffer, carrying zeros.
   always_ff @(posedge clk_i) begin
      if (w_fifo_push)
         r_fifo_mem[r_wptr] <= r_oob ? '0 : ram_data_i;
   end

endmodule

// File: tb/tb_bp_me_cache_dma_to_ram.sv
// Scoreboard bench for bp_me_cache_dma_to_ram: directed commands push expected traffic,
// a negedge monitor pops and compares RAM accesses and responses.
module tb_bp_me_cache_dma_to_ram;
   import bp_me_pkg::*;

   localparam int HW = cce_mem_msg_header_width_gp;
`ifdef BP_ME_DMA_RAM_BOUNDS_EN
   localparam logic [39:0] ADDR_HI = 40'h00_0000_0000;
`else
   localparam logic [39:0] ADDR_HI = 40'h00_8000_0000;
`endif

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic [HW-1:0] hdr_i = '0;
   logic          hdr_v_i = 1'b0;
   logic          hdr_yumi;
   logic [63:0]   data_i = '0;
   logic          data_v_i = 1'b0;
   logic          data_yumi;
   logic [HW-1:0] resp_hdr;
   logic          resp_hdr_v;
   logic          resp_hdr_ready_i = 1'b1;
   logic [63:0]   resp_data;
   logic          resp_data_v;
   logic          resp_data_ready_i = 1'b1;
   logic          ram_v, ram_w;
   logic [15:0]   ram_addr;
   logic [63:0]   ram_wdata;
   logic          ram_ready_i = 1'b1;
   logic [63:0]   ram_data_i;
   logic          error_o;

   bp_me_cache_dma_to_ram #(.ram_els_p(65536)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .mem_cmd_header_i(hdr_i), .mem_cmd_header_v_i(hdr_v_i), .mem_cmd_header_yumi_o(hdr_yumi),
      .mem_cmd_data_i(data_i), .mem_cmd_data_v_i(data_v_i), .mem_cmd_data_yumi_o(data_yumi),
      .mem_resp_header_o(resp_hdr), .mem_resp_header_v_o(resp_hdr_v),
      .mem_resp_header_ready_i(resp_hdr_ready_i),
      .mem_resp_data_o(resp_data), .mem_resp_data_v_o(resp_data_v),
      .mem_resp_data_ready_i(resp_data_ready_i),
      .ram_v_o(ram_v), .ram_w_o(ram_w), .ram_addr_o(ram_addr), .ram_data_o(ram_wdata),
      .ram_ready_i(ram_ready_i), .ram_data_i(ram_data_i), .error_o(error_o)
   );

   always #5 clk = ~clk;

   logic [HW-1:0] exp_hdr_q[$];
   logic [63:0]   exp_beat_q[$];
   logic [79:0]   exp_wr_q[$];
   logic [15:0]   exp_rd_q[$];

   int n_checks = 0, n_pass = 0;
   int cyc = 0, t_acc = 0, outstanding = 0, beats_seen = 0, bounds_ram_v = 0;
   bit lat_en = 1'b0, first_pend = 1'b0, bounds_en = 1'b0, bp_en = 1'b0;
   logic [3:0] bp_pat = 4'b1001;
   int bp_idx = 0;
   logic [63:0] tb_mem [0:65535];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   task automatic fail_now(input string name, input string what);
      n_checks++;
      $display("FAIL %s: actual %s", name, what);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: reads return data exactly one cycle after acceptance
   always @(posedge clk) begin
      if (ram_v && ram_ready_i) begin
         if (ram_w) tb_mem[ram_addr] <= ram_wdata;
         else       ram_data_i <= tb_mem[ram_addr];
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (bp_en) begin
         resp_data_ready_i = bp_pat[bp_idx];
         bp_idx = (bp_idx + 1) % 4;
      end else begin
         resp_data_ready_i = 1'b1;
         bp_idx = 0;
      end
   end

   always @(negedge clk) begin
      bp_bedrock_mem_header_s h_mon;
      h_mon = hdr_i;
      if (reset_i) begin
         outstanding = 0;
         first_pend  = 1'b0;
      end else begin
         if (outstanding >= 2) chk("ram_v_stall", ram_v, 1'b0);
         if (bounds_en && ram_v) bounds_ram_v++;
         if (hdr_yumi && hdr_v_i && h_mon.msg_type != e_bedrock_mem_wr) begin
            t_acc = cyc;
            first_pend = 1'b1;
         end
         if (resp_hdr_v && resp_hdr_ready_i) begin
            if (exp_hdr_q.size() == 0) fail_now("resp_hdr", "unexpected header");
            else chk("resp_hdr", resp_hdr, exp_hdr_q.pop_front());
         end
         if (resp_data_v && resp_data_ready_i) begin
            beats_seen++;
            if (outstanding > 0) outstanding--;
            if (first_pend && lat_en) chk("rd_latency", cyc - t_acc, 3);
            first_pend = 1'b0;
            if (exp_beat_q.size() == 0) fail_now("resp_beat", "unexpected beat");
            else chk("resp_beat", resp_data, exp_beat_q.pop_front());
         end
         if (ram_v && ram_ready_i && ram_w) begin
            if (exp_wr_q.size() == 0) fail_now("ram_write", "unexpected write");
            else chk("ram_write", {ram_addr, ram_wdata}, exp_wr_q.pop_front());
         end
         if (ram_v && ram_ready_i && !ram_w) begin
            outstanding++;
            if (exp_rd_q.size() == 0) fail_now("ram_read", "unexpected read");
            else chk("ram_read", ram_addr, exp_rd_q.pop_front());
         end
      end
   end

   function automatic logic [63:0] beat(input logic [55:0] hi, input int i);
      logic [7:0] lo;
      lo = 8'(8'h11 * (i + 1));
      return {hi, lo};
   endfunction

   task automatic send_hdr(input bp_bedrock_mem_type_e t, input logic [39:0] a);
      bp_bedrock_mem_header_s h;
      int k;
      h.payload = 16'h5A3C; h.size = 3'd6; h.addr = a; h.msg_type = t;
      exp_hdr_q.push_back(h);
      @(posedge clk); #1;
      hdr_i = h; hdr_v_i = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!hdr_yumi && k < 50);
      if (!hdr_yumi) fail_now("hdr_accept", "timeout");
      @(posedge clk); #1;
      hdr_v_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while ((exp_hdr_q.size() + exp_beat_q.size() + exp_wr_q.size() + exp_rd_q.size()) != 0
             && k < 300) begin
         @(negedge clk); #1; k++;
      end
      chk(name, exp_hdr_q.size() + exp_beat_q.size() + exp_wr_q.size() + exp_rd_q.size(), 0);
   endtask

   task automatic do_write(input logic [39:0] a, input logic [15:0] idx, input logic [55:0] hi,
                           input int stall_beat);
      int k;
      send_hdr(e_bedrock_mem_wr, a);
      for (int i = 0; i < 8; i++) begin
         exp_wr_q.push_back({idx + 16'(i), beat(hi, i)});
         @(posedge clk); #1;
         data_i = beat(hi, i); data_v_i = 1'b1;
         if (i == stall_beat) begin
            ram_ready_i = 1'b0;
            repeat (5) begin @(negedge clk); chk("stall_yumi", data_yumi, 1'b0); end
            @(posedge clk); #1;
            ram_ready_i = 1'b1;
         end
         k = 0;
         do begin @(negedge clk); k++; end while (!data_yumi && k < 50);
         if (!data_yumi) fail_now("data_accept", "timeout");
      end
      @(posedge clk); #1;
      data_v_i = 1'b0;
      drain("write_done");
   endtask

   task automatic push_read(input logic [15:0] idx, input logic [55:0] hi);
      for (int i = 0; i < 8; i++) begin
         exp_rd_q.push_back(idx + 16'(i));
         exp_beat_q.push_back(beat(hi, i));
      end
   endtask

   localparam logic [55:0] HI2 = 56'hC0_FFEE_1234_5678;

   initial begin
      int k, start;
      repeat (3) @(posedge clk);
      #1 reset_i = 1'b0;
      @(negedge clk);
      chk("rst_hdr_v", resp_hdr_v, 1'b0);
      chk("rst_data_v", resp_data_v, 1'b0);
      chk("rst_ram_v", ram_v, 1'b0);
      chk("rst_data_yumi", data_yumi, 1'b0);
      chk("rst_error", error_o, 1'b0);

      // write then read, including unaligned read of the same block
      do_write(ADDR_HI | 40'h40, 16'h0008, 56'h0, -1);
      lat_en = 1'b1;
      push_read(16'h0008, 56'h0);
      send_hdr(e_bedrock_mem_rd, ADDR_HI | 40'h40);
      drain("read_done");
      push_read(16'h0008, 56'h0);
      send_hdr(e_bedrock_mem_rd, ADDR_HI | 40'h58);
      drain("unaligned_done");

      // consumer backpressure 1-0-0-1
      lat_en = 1'b0; bp_en = 1'b1;
      push_read(16'h0008, 56'h0);
      send_hdr(e_bedrock_mem_rd, ADDR_HI | 40'h40);
      drain("bp_done");
      bp_en = 1'b0;
      @(posedge clk); #1;

      // RAM stall at beat 3, then read back
      lat_en = 1'b1;
      do_write(ADDR_HI | 40'h80, 16'h0010, HI2, 3);
      push_read(16'h0010, HI2);
      send_hdr(e_bedrock_mem_rd, ADDR_HI | 40'h80);
      drain("stall_read_done");

      // reset after three beats of a read
      push_read(16'h0010, HI2);
      start = beats_seen;
      send_hdr(e_bedrock_mem_rd, ADDR_HI | 40'h80);
      k = 0;
      while (beats_seen < start + 3 && k < 100) begin @(negedge clk); #1; k++; end
      if (beats_seen < start + 3) fail_now("midread_beats", "timeout");
      @(posedge clk); #1 reset_i = 1'b1;
      @(posedge clk); #1 reset_i = 1'b0;
      @(negedge clk);
      chk("rst_mid_hdr_v", resp_hdr_v, 1'b0);
      chk("rst_mid_data_v", resp_data_v, 1'b0);
      chk("rst_mid_ram_v", ram_v, 1'b0);
      chk("rst_mid_data_yumi", data_yumi, 1'b0);
      exp_beat_q.delete();
      exp_rd_q.delete();
      exp_hdr_q.delete();
      push_read(16'h0008, 56'h0);
      send_hdr(e_bedrock_mem_rd, ADDR_HI | 40'h40);
      drain("post_reset_read");

`ifdef BP_ME_DMA_RAM_BOUNDS_EN
      lat_en = 1'b0; bounds_en = 1'b1; bounds_ram_v = 0;
      for (int i = 0; i < 8; i++) exp_beat_q.push_back(64'h0);
      send_hdr(e_bedrock_mem_rd, 40'h08_0000);
      drain("oob_done");
      bounds_en = 1'b0;
      chk("oob_no_ram", bounds_ram_v, 0);
      chk("oob_error_set", error_o, 1'b1);
      push_read(16'h0008, 56'h0);
      send_hdr(e_bedrock_mem_rd, 40'h40);
      drain("oob_after_read");
      chk("oob_error_sticky", error_o, 1'b1);
`else
      chk("error_tied", error_o, 1'b0);
`endif

      repeat (3) @(negedge clk);
      chk("final_queues", exp_hdr_q.size() + exp_beat_q.size() + exp_wr_q.size() + exp_rd_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual simulation still running, required finish");
      $fatal(1);
   end

endmodule
